// File: rtl/serial_tx_if.sv
// Handshake and serial-line bundle between a word producer and serial_tx.
// master drives the word and load request; slave is the transmitter itself.
interface serial_tx_if #(
  parameter int unsigned DATA_W = 8
);
  logic [DATA_W-1:0] data_in;
  logic              load;
  logic              ready;
  logic              tx;
  logic              busy;
  logic              done;

  modport master (
    output data_in, load,
    input  ready, tx, busy, done
  );

  modport slave (
    input  data_in, load,
    output ready, tx, busy, done
  );
endinterface

// File: rtl/serial_tx.sv
// Serialises a word as start / data LSB-first / [parity] / stop, CLKS_PER_BIT clocks per bit.
// Define SERIAL_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module serial_tx #(
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input logic        clk,
  input logic        clear_n,
  serial_tx_if.slave sif_io
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT + 1);
  localparam int unsigned IdxW = $clog2(DATA_W + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(CLKS_PER_BIT - 1);
  localparam logic [IdxW-1:0] IdxMax = IdxW'(DATA_W - 1);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StStart  = 3'd1;
  localparam logic [2:0] StData   = 3'd2;
  localparam logic [2:0] StStop   = 3'd4;
`ifdef SERIAL_TX_PARITY_EN
  localparam logic [2:0] StParity = 3'd3;
`endif

  logic [2:0]        state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              tx_q, tx_d;
  logic              done_q, done_d;
  logic              bit_end;
`ifdef SERIAL_TX_PARITY_EN
  logic              parity_q, parity_d;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    done_d  = 1'b0;
    bit_end = (cnt_q == CntMax);
`ifdef SERIAL_TX_PARITY_EN
    parity_d = parity_q;
`endif

    case (state_q)
      StIdle: begin
        if (sif_io.load) begin
          state_d = StStart;
          cnt_d   = '0;
          idx_d   = '0;
          shift_d = sif_io.data_in;
`ifdef SERIAL_TX_PARITY_EN
          parity_d = ^sif_io.data_in;
`endif
        end
      end
      StStart: begin
        if (bit_end) begin
          state_d = StData;
          cnt_d   = '0;
          idx_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StData: begin
        if (bit_end) begin
          cnt_d   = '0;
          shift_d = shift_q >> 1;
          if (idx_q == IdxMax) begin
            idx_d = '0;
`ifdef SERIAL_TX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end else begin
            idx_d = idx_q + IdxW'(1);
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
`ifdef SERIAL_TX_PARITY_EN
      StParity: begin
        if (bit_end) begin
          state_d = StStop;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
`endif
      StStop: begin
        if (bit_end) begin
          state_d = StIdle;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
        idx_d   = '0;
      end
    endcase

    // tx is decoded from the next state so the register output changes on the entering edge.
    case (state_d)
      StStart:  tx_d = 1'b0;
      StData:   tx_d = shift_d[0];
`ifdef SERIAL_TX_PARITY_EN
      StParity: tx_d = parity_q;
`endif
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
      done_q   <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
      done_q   <= done_d;
`ifdef SERIAL_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign sif_io.ready = (state_q == StIdle);
  assign sif_io.busy  = (state_q != StIdle);
  assign sif_io.tx    = tx_q;
  assign sif_io.done  = done_q;

endmodule
